// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared definitions for the execute stage.
//   - ALUControl operation codes ALU_AND .. ALU_MFLO
//   - mul/div engine state codes (2 bits)
//   - True_v / False_v single-bit constants
//   - default mul/div iteration count
package ex_stage_pkg;

  localparam logic True_v  = 1'b1;
  localparam logic False_v = 1'b0;

  localparam int MdCyclesDefault = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_MULT = 4'b1100;
  localparam logic [3:0] ALU_DIV  = 4'b1101;
  localparam logic [3:0] ALU_MFHI = 4'b1110;
  localparam logic [3:0] ALU_MFLO = 4'b1111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } mdState_e;

endpackage

// File: rtl/ex_stage_muldiv_iter.sv
// muldiv_iter: iterative signed multiply / divide producing HI and LO.
// One shift-add (MULT) or shift-subtract (DIV) step per cycle on operand
// magnitudes; signs are restored on the final step, when HI/LO are written.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   MD_IDLE | waiting; start latches magnitudes and signs, busy asserted
//   MD_BUSY | one step per cycle; last step writes the signed HI/LO
//   MD_DONE | result visible; the held instruction retires, no restart
//
// Ports:
//   Clk, Rst     clock (rising edge), async active-high reset
//   start        MULT or DIV presented by the execute stage
//   op           0: MULT, 1: DIV
//   a, b         signed operands (dividend / divisor for DIV)
//   busy         combinational; high from the start cycle through BUSY
//   hi, lo       result registers
module muldiv_iter
  import ex_stage_pkg::*;
#(
  parameter int MD_CYCLES = MdCyclesDefault
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdState_e    state, stateNext;
  logic [4:0]  cnt;
  logic        isDiv, negRes, negRem, divZero;
  logic [31:0] mcand;
  // MULT: {partial product, remaining multiplier bits}
  // DIV:  {partial remainder, dividend bits / quotient bits}
  logic [63:0] acc;
  logic [63:0] accStep;
  logic [32:0] addSum, remTrial, remDiff;
  logic [63:0] prodSigned;
  logic [31:0] remMag, quoMag;
  logic        lastStep;

  assign lastStep = (state == MD_BUSY) && (cnt == 5'(MD_CYCLES - 1));

  always_comb begin
    stateNext = state;
    busy      = False_v;
    case (state)
      MD_IDLE: if (start) begin
        stateNext = MD_BUSY;
        busy      = True_v;
      end
      MD_BUSY: begin
        busy = True_v;
        if (lastStep) stateNext = MD_DONE;
      end
      MD_DONE: stateNext = MD_IDLE;
      default: stateNext = MD_IDLE;
    endcase
    // Upstream must never see a stall while the block is held in reset.
    if (Rst) busy = False_v;
  end

  always_comb begin
    addSum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    remTrial = acc[63:31];
    remDiff  = remTrial - {1'b0, mcand};
    accStep  = {addSum, acc[31:1]};
    if (isDiv) begin
      if (remTrial >= {1'b0, mcand}) accStep = {remDiff[31:0], acc[30:0], 1'b1};
      else                           accStep = {remTrial[31:0], acc[30:0], 1'b0};
    end
    prodSigned = negRes ? (64'd0 - accStep) : accStep;
    remMag     = accStep[63:32];
    quoMag     = accStep[31:0];
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      isDiv   <= False_v;
      negRes  <= False_v;
      negRem  <= False_v;
      divZero <= False_v;
      mcand   <= '0;
      acc     <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= stateNext;
      if (state == MD_IDLE && start) begin
        cnt     <= '0;
        isDiv   <= op;
        negRes  <= a[31] ^ b[31];
        negRem  <= a[31];
        divZero <= (b == 32'd0);
        mcand   <= b[31] ? (32'd0 - b) : b;
        acc     <= {32'd0, (a[31] ? (32'd0 - a) : a)};
      end else if (state == MD_BUSY) begin
        cnt <= cnt + 5'd1;
        acc <= accStep;
        if (lastStep) begin
          if (!isDiv) begin
            hi <= prodSigned[63:32];
            lo <= prodSigned[31:0];
          end else begin
            // Remainder keeps the dividend's sign, which for a zero divisor
            // reproduces the dividend itself.
            hi <= negRem ? (32'd0 - remMag) : remMag;
            if (divZero)     lo <= 32'hFFFF_FFFF;
            else if (negRes) lo <= 32'd0 - quoMag;
            else             lo <= quoMag;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage between the ID/EX and EX/MEM pipeline registers.
// Operand muxes, single-cycle ALU, stall generation and EX/MEM registers.
// Build option: EX_MULDIV_EN enables the HI/LO mul/div engine (muldiv_iter);
// without it ops 1100-1111 retire with result 0 and no register write.
//
// Ports:
//   Clk, Rst                          clock, async active-high reset
//   EX_RegDst/ALUSrcA/ALUSrcB         destination and operand selects
//   EX_RegWrite/MemWrite/MemToReg     control passed to MEM
//   EX_ALUControl                     operation code
//   EX_Shamt/RegA/RegB/ImmExt         operands
//   EX_Regrt/Regrd                    register specifiers
//   Stall                             holds PC, IF/ID and ID/EX while high
//   MEM_*                             registered EX/MEM outputs
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MD_CYCLES = MdCyclesDefault
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        EX_RegDst,
  input  logic        EX_ALUSrcA,
  input  logic        EX_ALUSrcB,
  input  logic        EX_RegWrite,
  input  logic        EX_MemWrite,
  input  logic        EX_MemToReg,
  input  logic [3:0]  EX_ALUControl,
  input  logic [31:0] EX_Shamt,
  input  logic [31:0] EX_RegA,
  input  logic [31:0] EX_RegB,
  input  logic [31:0] EX_ImmExt,
  input  logic [4:0]  EX_Regrt,
  input  logic [4:0]  EX_Regrd,
  output logic        Stall,
  output logic        MEM_RegWrite,
  output logic        MEM_MemWrite,
  output logic        MEM_MemToReg,
  output logic [31:0] MEM_ALUResult,
  output logic [31:0] MEM_WriteData,
  output logic [4:0]  MEM_WriteReg
);

  // The iteration counter is 5 bits wide.
  if (MD_CYCLES < 2 || MD_CYCLES > 32) begin : gBadMdCycles
    $error("ex_stage: MD_CYCLES out of range");
  end

  logic [31:0] opA, opB, aluResult;
  logic [4:0]  writeReg;
  logic        bubble, noWrite;
  logic [31:0] hiVal, loVal;

  assign opA      = EX_ALUSrcA ? EX_Shamt : EX_RegA;
  assign opB      = EX_ALUSrcB ? EX_ImmExt : EX_RegB;
  assign writeReg = EX_RegDst ? EX_Regrd : EX_Regrt;

`ifdef EX_MULDIV_EN
  logic isMulDiv, mdBusy;

  assign isMulDiv = (EX_ALUControl == ALU_MULT) || (EX_ALUControl == ALU_DIV);

  muldiv_iter #(.MD_CYCLES(MD_CYCLES)) uMulDiv (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (isMulDiv),
    .op    (EX_ALUControl == ALU_DIV),
    .a     (EX_RegA),
    .b     (EX_RegB),
    .busy  (mdBusy),
    .hi    (hiVal),
    .lo    (loVal)
  );

  assign Stall = mdBusy;
  // MULT/DIV never writes a GPR, including the retiring cycle in DONE.
  assign bubble  = isMulDiv || mdBusy;
  assign noWrite = False_v;
`else
  assign hiVal   = '0;
  assign loVal   = '0;
  assign Stall   = False_v;
  assign bubble  = False_v;
  assign noWrite = (EX_ALUControl[3:2] == 2'b11);
`endif

  always_comb begin
    aluResult = '0;
    case (EX_ALUControl)
      ALU_AND:  aluResult = opA & opB;
      ALU_OR:   aluResult = opA | opB;
      ALU_ADD:  aluResult = opA + opB;
      ALU_XOR:  aluResult = opA ^ opB;
      ALU_NOR:  aluResult = ~(opA | opB);
      ALU_SLL:  aluResult = opB << opA[4:0];
      ALU_SRL:  aluResult = opB >> opA[4:0];
      ALU_SRA:  aluResult = $signed(opB) >>> opA[4:0];
      ALU_SUB:  aluResult = opA - opB;
      ALU_SLT:  aluResult = {31'd0, $signed(opA) < $signed(opB)};
      ALU_SLTU: aluResult = {31'd0, opA < opB};
      ALU_LUI:  aluResult = opB << 16;
      ALU_MFHI: aluResult = hiVal;
      ALU_MFLO: aluResult = loVal;
      default:  aluResult = '0;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      MEM_RegWrite  <= False_v;
      MEM_MemWrite  <= False_v;
      MEM_MemToReg  <= False_v;
      MEM_ALUResult <= '0;
      MEM_WriteData <= '0;
      MEM_WriteReg  <= '0;
    end else if (bubble) begin
      MEM_RegWrite  <= False_v;
      MEM_MemWrite  <= False_v;
      MEM_MemToReg  <= False_v;
      MEM_ALUResult <= '0;
      MEM_WriteData <= '0;
      MEM_WriteReg  <= '0;
    end else begin
      MEM_RegWrite  <= EX_RegWrite && !noWrite;
      MEM_MemWrite  <= EX_MemWrite;
      MEM_MemToReg  <= EX_MemToReg;
      MEM_ALUResult <= aluResult;
      MEM_WriteData <= EX_RegB;
      MEM_WriteReg  <= writeReg;
    end
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage, directly downstream of the ID/EX pipeline register; consumes its EX_* control and data outputs.
- Computes single-cycle ALU results and runs an iterative 32-cycle signed multiply/divide into HI/LO.
- Registers results into the EX/MEM boundary.
- Raises Stall to freeze PC, IF/ID and ID/EX while a multiply/divide is in progress.

Parameters:
- MD_CYCLES, 32, iteration count of the mul/div engine; the counter is 5 bits wide.

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- EX_RegDst  in  1  1: destination is Regrd, 0: Regrt
- EX_ALUSrcA  in  1  1: operand A = Shamt, 0: RegA
- EX_ALUSrcB  in  1  1: operand B = ImmExt, 0: RegB
- EX_RegWrite / EX_MemWrite / EX_MemToReg  in  1 each  control, passed through
- EX_ALUControl  in  4  operation code
- EX_Shamt / EX_RegA / EX_RegB / EX_ImmExt  in  32 each  operands
- EX_Regrt / EX_Regrd  in  5 each  register specifiers
- Stall  out  1  combinational; upstream stages hold their contents while it is 1
- MEM_RegWrite / MEM_MemWrite / MEM_MemToReg  out  1 each  registered control
- MEM_ALUResult  out  32  registered result
- MEM_WriteData  out  32  registered RegB, the store data
- MEM_WriteReg  out  5  registered destination register

Behaviour:
- ALUControl encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLL, 0110 SRL, 0111 SRA
  - 1000 SUB, 1001 SLT (signed), 1010 SLTU, 1011 LUI (B<<16)
  - 1100 MULT, 1101 DIV, 1110 MFHI, 1111 MFLO
- Shifts shift B by A[4:0]. ADD/SUB wrap modulo 2^32; there is no overflow trap.
- Normal ops: result appears on MEM_* one cycle after the inputs are presented (latency 1).
- Reset values: all MEM_* = 0, HI = LO = 0, FSM = IDLE, counter = 0. Stall = 0 while in reset.
- Mul/div FSM states are IDLE, BUSY and DONE.
- IDLE:
  - Op 1100/1101 present: Stall = 1 in the same cycle. Operands are latched as magnitudes plus sign flags. Next state BUSY, counter = 0.
  - Any other op: executes normally.
- BUSY:
  - Stall = 1 and one shift-add or shift-subtract step per cycle. MEM_* receive a bubble (all control = 0, data = 0).
  - At counter == MD_CYCLES-1: sign correction is applied, HI/LO are written at that edge, next state DONE.
- DONE:
  - Stall = 0. The still-present MULT/DIV is retired as a bubble (it never writes a GPR) and does not restart.
  - Next state IDLE.
- Stall is high for exactly MD_CYCLES+1 = 33 cycles per MULT/DIV.
- MULT: {HI,LO} = signed 64-bit product.
- DIV: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
- Divide by zero: still 33 cycles; LO = 32'hFFFFFFFF, HI = dividend.
- MFHI/MFLO immediately after the DONE cycle return the new HI/LO (written before DONE).
- Reset asserted mid-BUSY: FSM goes to IDLE and HI/LO are cleared immediately; the partial result is discarded.
- A MULT/DIV arriving while a previous one is in DONE is impossible: upstream was held, so the op in DONE is that same instruction.

Optional Feature:
- Macro: EX_MULDIV_EN.
- Defined: full HI/LO and mul/div engine as above.
- Undefined:
  - No HI/LO, FSM or counter; Stall tied 0.
  - Ops 1100–1111 produce MEM_ALUResult = 0 and MEM_RegWrite = 0, with latency 1 like any other op.

Decomposition:
- Shared defines file holds:
  - the 16 ALUControl codes, named ALU_AND … ALU_MFLO;
  - the mul/div FSM state codes (2 bits);
  - True_v/False_v, alongside the existing ones.
- One sub-module, muldiv_iter: FSM, counter, operand/partial registers, sign fix-up and HI/LO. It exposes start, op, a, b, busy, hi, lo.
- ex_stage keeps the operand muxes, the combinational ALU, Stall generation and the EX/MEM registers.

Test Plan:
- ADD, ALUSrcB=1, RegA=32'h10, ImmExt=32'hFFFFFFFC, RegDst=0, Regrt=5 -> next cycle MEM_ALUResult=32'hC, MEM_WriteReg=5, MEM_RegWrite=1.
- SLL, ALUSrcA=1, Shamt=4, RegB=32'h8000_0001 -> MEM_ALUResult=32'h0000_0010. SRA, Shamt=4, RegB=32'h8000_0000 -> 32'hF800_0000.
- MULT RegA=-3, RegB=7, then MFLO, then MFHI -> Stall high exactly 33 cycles, MEM_RegWrite=0 throughout; MFLO gives 32'hFFFFFFEB, MFHI gives 32'hFFFFFFFF.
- DIV RegA=100, RegB=-7, then MFLO/MFHI -> LO=32'hFFFFFFF2 (-14), HI=2. DIV RegA=5, RegB=0 -> LO=32'hFFFFFFFF, HI=5, 33-cycle stall.
- Assert Rst during BUSY (counter=10) -> Stall=0 and MEM_*=0 immediately; MFHI after release returns 0; a following ADD completes with latency 1.
- Build with EX_MULDIV_EN undefined, issue MULT -> Stall never asserts; MEM_ALUResult=0, MEM_RegWrite=0 next cycle.
